mem_bus_decoder: RTL

- Parametrised, registered address decoder and response mux for the picorv32 native memory bus.
- Replaces hand-written per-peripheral select and ready/rdata logic in the SoC top.
- Routes one master to NUM_SLAVES slaves using base/mask windows.
- Adds what ad-hoc decoding lacks: unmapped-access completion, a per-transaction timeout watchdog and a sticky error record, so the CPU never hangs on a bad address or a dead peripheral.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/addr_match.sv | 27 ++
 rtl/mem_bus_decoder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the picorv32 native-bus decoder.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_code_t;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

    // Slave index width; a single-slave bus still carries a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_match.sv
// Combinational base/mask window compare with lowest-index priority.
module addr_match
    import bus_pkg::*;
#(
    parameter int                        NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE = {32'h80000020, 32'h80000008, 32'h80000000, 32'h00000000},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK = {32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'hFFFE0000},
    parameter int                        IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scanning downwards lets the lowest matching index overwrite the others.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_decoder.sv
// Registered address decoder and response mux for the picorv32 native bus,
// with unmapped completion, per-transaction timeout and a sticky error record.
module mem_bus_decoder
    import bus_pkg::*;
#(
    parameter int                        NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {32'h80000020, 32'h80000008, 32'h80000000, 32'h00000000},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'hFFFE0000},
    parameter int                        TIMEOUT_CYCLES = 16,
    parameter logic [31:0]               ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_valid,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic                     m_ready,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_sel,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                     err_valid,
    output logic [1:0]               err_code,
    output logic [31:0]              err_addr,
    output logic [7:0]               err_count,
    input  logic                     err_clear
);

    localparam int               IDX_W    = idx_width(NUM_SLAVES);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sel_idx_q;
    logic [CNT_W-1:0] tcount_q;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             ready_sel;
    logic [31:0]      slave_rdata;
    logic             err_event;
    err_code_t        err_new;
    logic [31:0]      err_new_addr;

    function automatic logic [NUM_SLAVES-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .IDX_W      (IDX_W)
    ) u_addr_match (
        .addr (m_addr),
        .hit  (match_hit),
        .idx  (match_idx)
    );

    // Only the selected slave's ready and data are ever looked at.
    assign ready_sel   = s_ready[sel_idx_q];
    assign slave_rdata = s_rdata[{sel_idx_q, 5'd0} +: 32];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        m_ready      = 1'b0;
        err_event    = 1'b0;
        err_new      = ERR_NONE;
        err_new_addr = m_addr;
        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    if (match_hit) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d      = RESP;
                        err_event    = 1'b1;
                        err_new      = ERR_UNMAPPED;
                        err_new_addr = m_addr;
                    end
                end
            end
            ACTIVE: begin
                // A ready on the final allowed cycle beats the timeout.
                if (ready_sel) begin
                    state_d = RESP;
                end else if (tcount_q == CNT_LAST) begin
                    state_d      = RESP;
                    err_event    = 1'b1;
                    err_new      = ERR_TIMEOUT;
                    err_new_addr = s_addr;
                end
            end
            RESP: begin
                m_ready = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_sel     <= '0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
            sel_idx_q <= '0;
            tcount_q  <= '0;
            m_rdata   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_valid) begin
                        s_addr    <= m_addr;
                        s_wdata   <= m_wdata;
                        s_wstrb   <= m_wstrb;
                        sel_idx_q <= match_idx;
                        tcount_q  <= '0;
                        if (match_hit) begin
                            s_sel <= onehot(match_idx);
                        end else begin
                            m_rdata <= ERR_RDATA;
                        end
                    end
                end
                ACTIVE: begin
                    if (ready_sel) begin
                        m_rdata <= slave_rdata;
                        s_sel   <= '0;
                    end else if (tcount_q == CNT_LAST) begin
                        m_rdata <= ERR_RDATA;
                        s_sel   <= '0;
                    end else begin
                        tcount_q <= tcount_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Count every error, but keep the details of the first one until cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
            err_count <= '0;
        end else if (err_event) begin
            err_count <= err_clear ? 8'd1 : sat_inc(err_count);
            if (err_clear || !err_valid) begin
                err_valid <= 1'b1;
                err_code  <= err_new;
                err_addr  <= err_new_addr;
            end
        end else if (err_clear) begin
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
            err_count <= '0;
        end
    end

endmodule
